// File: rtl/sram_port_arbiter_if.sv
// Signal bundle between the fetch requester, the data-path requester, the SRAM
// macro and sram_port_arbiter. The arbiter uses the slave modport.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);

    // Fetch requester
    logic              FetchReq;
    logic [ADDR_W-1:0] FetchAddr;
    logic              FetchGnt;
    logic              FetchDone;
    logic [DATA_W-1:0] FetchData;

    // Data-path requester (LDURSW / STURW)
    logic              DataReq;
    logic              DataRNW;
    logic [ADDR_W-1:0] DataAddr;
    logic [DATA_W-1:0] DataWData;
    logic              DataGnt;
    logic              DataDone;
    logic [DATA_W-1:0] DataRData;

    // SRAM macro port
    logic              SramCE;
    logic              SramOE;
    logic              SramRNW;
    logic [ADDR_W-1:0] SramAddr;
    logic [DATA_W-1:0] SramWData;
    logic [DATA_W-1:0] SramRData;

    // Status and FSM state for observation
    logic              Busy;
    logic [1:0]        DbgState;

    modport slave (
        input  FetchReq, FetchAddr,
        output FetchGnt, FetchDone, FetchData,
        input  DataReq, DataRNW, DataAddr, DataWData,
        output DataGnt, DataDone, DataRData,
        output SramCE, SramOE, SramRNW, SramAddr, SramWData,
        input  SramRData,
        output Busy, DbgState
    );

    modport master (
        output FetchReq, FetchAddr,
        input  FetchGnt, FetchDone, FetchData,
        output DataReq, DataRNW, DataAddr, DataWData,
        input  DataGnt, DataDone, DataRData,
        input  SramCE, SramOE, SramRNW, SramAddr, SramWData,
        output SramRData,
        input  Busy, DbgState
    );

endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port between instruction fetch (read-only) and the data path,
// running a fixed WAIT-cycle access followed by a one-cycle Done turnaround.
module sram_port_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 16,
    parameter int WAIT       = 2,
    parameter int STARVE_MAX = 4
) (
    input logic                Clock,
    input logic                Reset,
    sram_port_arbiter_if.slave bus
);

    // Handshake: a requester raises Req and holds it until its Done pulse; Req
    // is sampled only in IDLE, so a Req still high after Done is a new request.
    // Gnt covers ACCESS and DONE, and Done is a single cycle.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_LOAD   = CW'(WAIT - 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              owner_data_q, owner_data_d;
    logic              rnw_q, rnw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] fdata_q, fdata_d;
    logic [DATA_W-1:0] drdata_q, drdata_d;
    logic              data_wins;

    // Data has priority unless fetch has already lost STARVE_MAX times in a row.
    assign data_wins = bus.DataReq && !(bus.FetchReq && (starve_q == STARVE_TOP));

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            starve_q     <= '0;
            owner_data_q <= 1'b0;
            rnw_q        <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            fdata_q      <= '0;
            drdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            starve_q     <= starve_d;
            owner_data_q <= owner_data_d;
            rnw_q        <= rnw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            fdata_q      <= fdata_d;
            drdata_q     <= drdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        starve_d     = starve_q;
        owner_data_d = owner_data_q;
        rnw_d        = rnw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        fdata_d      = fdata_q;
        drdata_d     = drdata_q;

        unique case (state_q)
            IDLE: begin
                if (data_wins) begin
                    state_d      = ACCESS;
                    cnt_d        = CNT_LOAD;
                    owner_data_d = 1'b1;
                    rnw_d        = bus.DataRNW;
                    addr_d       = bus.DataAddr;
                    wdata_d      = bus.DataWData;
                    if (bus.FetchReq && (starve_q != STARVE_TOP)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (bus.FetchReq) begin
                    state_d      = ACCESS;
                    cnt_d        = CNT_LOAD;
                    owner_data_d = 1'b0;
                    rnw_d        = 1'b1;
                    addr_d       = bus.FetchAddr;
                    starve_d     = '0;
                end
            end

            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    // SramRData is valid only in the final ACCESS cycle.
                    if (rnw_q) begin
                        if (owner_data_q) begin
                            drdata_d = bus.SramRData;
                        end else begin
                            fdata_d = bus.SramRData;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.FetchGnt  = (state_q != IDLE) && !owner_data_q;
    assign bus.DataGnt   = (state_q != IDLE) &&  owner_data_q;
    assign bus.FetchDone = (state_q == DONE) && !owner_data_q;
    assign bus.DataDone  = (state_q == DONE) &&  owner_data_q;
    assign bus.FetchData = fdata_q;
    assign bus.DataRData = drdata_q;

    assign bus.SramCE    = (state_q == ACCESS);
    assign bus.SramOE    = (state_q == ACCESS) && rnw_q;
    assign bus.SramRNW   = (state_q == ACCESS) ? rnw_q : 1'b1;
    assign bus.SramAddr  = addr_q;
    assign bus.SramWData = wdata_q;

    assign bus.Busy      = (state_q != IDLE);
    assign bus.DbgState  = state_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: one task per scenario, inline checks,
// grant-exclusivity monitor and a single summary line.
module tb_sram_port_arbiter;

  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 16;
  localparam int WAIT       = 2;
  localparam int STARVE_MAX = 4;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT(WAIT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // Grants must never overlap.
  always @(negedge Clock) begin
    total++;
    if ((bus.FetchGnt && bus.DataGnt) !== 1'b0) begin
      bad++;
      $display("FAIL gnt_excl: t=%0t FetchGnt=%b DataGnt=%b required not both",
               $time, bus.FetchGnt, bus.DataGnt);
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Reset = 1'b0;
    tick();
    tick();
    total++;
    if ({bus.FetchGnt, bus.FetchDone, bus.DataGnt, bus.DataDone,
         bus.SramCE, bus.SramOE, bus.SramRNW, bus.Busy} !== 8'b0000_0010) begin
      bad++;
      $display("FAIL reset_ctl: got %b required 00000010",
               {bus.FetchGnt, bus.FetchDone, bus.DataGnt, bus.DataDone,
                bus.SramCE, bus.SramOE, bus.SramRNW, bus.Busy});
    end
    total++;
    if ({bus.SramAddr, bus.SramWData, bus.FetchData, bus.DataRData} !== '0) begin
      bad++;
      $display("FAIL reset_data: addr=%h wdata=%h fdata=%h drdata=%h required all 0",
               bus.SramAddr, bus.SramWData, bus.FetchData, bus.DataRData);
    end
    total++;
    if (bus.DbgState !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: got %0d required 0", bus.DbgState);
    end
    Reset = 1'b1;
  endtask

  task automatic test_fetch_read();
    bus.FetchReq  = 1'b1;
    bus.FetchAddr = 11'h010;
    bus.SramRData = 16'h0000;
    for (int c = 0; c < WAIT; c++) begin
      tick();
      if (c == WAIT - 1) bus.SramRData = 16'hBEEF;
      total++;
      if ({bus.FetchGnt, bus.DataGnt, bus.SramCE, bus.SramOE, bus.SramRNW, bus.FetchDone} !== 6'b101110) begin
        bad++;
        $display("FAIL fetch_access%0d: gnt/dgnt/ce/oe/rnw/done=%b required 101110", c,
                 {bus.FetchGnt, bus.DataGnt, bus.SramCE, bus.SramOE, bus.SramRNW, bus.FetchDone});
      end
      total++;
      if (bus.SramAddr !== 11'h010) begin
        bad++;
        $display("FAIL fetch_addr%0d: got %h required 010", c, bus.SramAddr);
      end
    end
    tick();
    bus.SramRData = 16'h5555;
    bus.FetchReq  = 1'b0;
    total++;
    if ({bus.FetchDone, bus.FetchGnt, bus.SramCE, bus.SramOE, bus.SramRNW} !== 5'b11001) begin
      bad++;
      $display("FAIL fetch_done: done/gnt/ce/oe/rnw=%b required 11001",
               {bus.FetchDone, bus.FetchGnt, bus.SramCE, bus.SramOE, bus.SramRNW});
    end
    total++;
    if (bus.FetchData !== 16'hBEEF) begin
      bad++;
      $display("FAIL fetch_data: got %h required beef", bus.FetchData);
    end
    tick();
    total++;
    if ({bus.FetchDone, bus.FetchGnt, bus.Busy} !== 3'b000 || bus.FetchData !== 16'hBEEF) begin
      bad++;
      $display("FAIL fetch_idle: done/gnt/busy=%b fdata=%h required 000 beef",
               {bus.FetchDone, bus.FetchGnt, bus.Busy}, bus.FetchData);
    end
  endtask

  task automatic test_data_write();
    bus.DataReq   = 1'b1;
    bus.DataRNW   = 1'b0;
    bus.DataAddr  = 11'h7FF;
    bus.DataWData = 16'h1234;
    for (int c = 0; c < WAIT; c++) begin
      tick();
      // Later changes to requester inputs must not leak onto the SRAM bus.
      bus.DataAddr  = 11'h000;
      bus.DataWData = 16'hFFFF;
      bus.SramRData = 16'hAAAA;
      total++;
      if ({bus.DataGnt, bus.FetchGnt, bus.SramCE, bus.SramOE, bus.SramRNW} !== 5'b10100) begin
        bad++;
        $display("FAIL write_access%0d: dgnt/fgnt/ce/oe/rnw=%b required 10100", c,
                 {bus.DataGnt, bus.FetchGnt, bus.SramCE, bus.SramOE, bus.SramRNW});
      end
      total++;
      if (bus.SramAddr !== 11'h7FF || bus.SramWData !== 16'h1234) begin
        bad++;
        $display("FAIL write_bus%0d: addr=%h wdata=%h required 7ff 1234", c,
                 bus.SramAddr, bus.SramWData);
      end
    end
    tick();
    bus.DataReq = 1'b0;
    total++;
    if ({bus.DataDone, bus.DataGnt, bus.SramRNW} !== 3'b111 || bus.DataRData !== 16'h0000) begin
      bad++;
      $display("FAIL write_done: done/gnt/rnw=%b drdata=%h required 111 0000",
               {bus.DataDone, bus.DataGnt, bus.SramRNW}, bus.DataRData);
    end
    tick();
    total++;
    if (bus.Busy !== 1'b0 || bus.FetchData !== 16'hBEEF) begin
      bad++;
      $display("FAIL write_idle: busy=%b fdata=%h required 0 beef", bus.Busy, bus.FetchData);
    end
  endtask

  task automatic test_simultaneous();
    bus.FetchReq  = 1'b1;
    bus.FetchAddr = 11'h020;
    bus.DataReq   = 1'b1;
    bus.DataRNW   = 1'b1;
    bus.DataAddr  = 11'h030;
    tick();
    total++;
    if ({bus.DataGnt, bus.FetchGnt} !== 2'b10 || bus.SramAddr !== 11'h030) begin
      bad++;
      $display("FAIL sim_first: dgnt/fgnt=%b addr=%h required 10 030",
               {bus.DataGnt, bus.FetchGnt}, bus.SramAddr);
    end
    tick();
    bus.SramRData = 16'h1111;
    tick();
    bus.DataReq = 1'b0;
    total++;
    if ({bus.DataDone, bus.FetchDone} !== 2'b10 || bus.DataRData !== 16'h1111) begin
      bad++;
      $display("FAIL sim_ddone: ddone/fdone=%b drdata=%h required 10 1111",
               {bus.DataDone, bus.FetchDone}, bus.DataRData);
    end
    tick();
    total++;
    if ({bus.DataGnt, bus.FetchGnt, bus.Busy} !== 3'b000) begin
      bad++;
      $display("FAIL sim_turnaround: dgnt/fgnt/busy=%b required 000",
               {bus.DataGnt, bus.FetchGnt, bus.Busy});
    end
    tick();
    total++;
    if ({bus.DataGnt, bus.FetchGnt} !== 2'b01 || bus.SramAddr !== 11'h020) begin
      bad++;
      $display("FAIL sim_second: dgnt/fgnt=%b addr=%h required 01 020",
               {bus.DataGnt, bus.FetchGnt}, bus.SramAddr);
    end
    tick();
    bus.SramRData = 16'h2222;
    tick();
    bus.FetchReq = 1'b0;
    total++;
    if (bus.FetchDone !== 1'b1 || bus.FetchData !== 16'h2222 || bus.DataRData !== 16'h1111) begin
      bad++;
      $display("FAIL sim_fdone: fdone=%b fdata=%h drdata=%h required 1 2222 1111",
               bus.FetchDone, bus.FetchData, bus.DataRData);
    end
    tick();
  endtask

  task automatic test_starvation();
    logic exp_data [6];
    exp_data = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bus.FetchReq  = 1'b1;
    bus.FetchAddr = 11'h100;
    bus.DataReq   = 1'b1;
    bus.DataRNW   = 1'b1;
    bus.DataAddr  = 11'h200;
    for (int g = 0; g < 6; g++) begin
      tick();
      total++;
      if ({bus.DataGnt, bus.FetchGnt} !== {exp_data[g], ~exp_data[g]}) begin
        bad++;
        $display("FAIL starve_gnt%0d: dgnt/fgnt=%b required %b", g,
                 {bus.DataGnt, bus.FetchGnt}, {exp_data[g], ~exp_data[g]});
      end
      tick();
      tick();
      total++;
      if ({bus.DataDone, bus.FetchDone} !== {exp_data[g], ~exp_data[g]}) begin
        bad++;
        $display("FAIL starve_done%0d: ddone/fdone=%b required %b", g,
                 {bus.DataDone, bus.FetchDone}, {exp_data[g], ~exp_data[g]});
      end
      tick();
    end
    bus.FetchReq = 1'b0;
    bus.DataReq  = 1'b0;
  endtask

  task automatic test_req_drop();
    bus.DataReq  = 1'b1;
    bus.DataRNW  = 1'b1;
    bus.DataAddr = 11'h055;
    tick();
    bus.DataReq   = 1'b0;
    bus.SramRData = 16'h0000;
    total++;
    if (bus.DataGnt !== 1'b1 || bus.SramAddr !== 11'h055) begin
      bad++;
      $display("FAIL drop_gnt: dgnt=%b addr=%h required 1 055", bus.DataGnt, bus.SramAddr);
    end
    tick();
    bus.SramRData = 16'h3C3C;
    total++;
    if (bus.SramCE !== 1'b1) begin
      bad++;
      $display("FAIL drop_access: ce=%b required 1", bus.SramCE);
    end
    tick();
    total++;
    if (bus.DataDone !== 1'b1 || bus.DataRData !== 16'h3C3C) begin
      bad++;
      $display("FAIL drop_done: ddone=%b drdata=%h required 1 3c3c", bus.DataDone, bus.DataRData);
    end
    tick();
    tick();
    total++;
    if (bus.Busy !== 1'b0) begin
      bad++;
      $display("FAIL drop_no_regrant: busy=%b required 0", bus.Busy);
    end
  endtask

  task automatic test_reset_mid();
    bus.FetchReq  = 1'b1;
    bus.FetchAddr = 11'h0AA;
    tick();
    total++;
    if (bus.FetchGnt !== 1'b1 || bus.SramCE !== 1'b1) begin
      bad++;
      $display("FAIL rmid_pre: fgnt=%b ce=%b required 1 1", bus.FetchGnt, bus.SramCE);
    end
    #1 Reset = 1'b0;
    #1;
    total++;
    if ({bus.FetchGnt, bus.FetchDone, bus.DataGnt, bus.DataDone,
         bus.SramCE, bus.SramOE, bus.SramRNW, bus.Busy} !== 8'b0000_0010) begin
      bad++;
      $display("FAIL rmid_ctl: got %b required 00000010",
               {bus.FetchGnt, bus.FetchDone, bus.DataGnt, bus.DataDone,
                bus.SramCE, bus.SramOE, bus.SramRNW, bus.Busy});
    end
    total++;
    if ({bus.SramAddr, bus.SramWData, bus.FetchData, bus.DataRData} !== '0) begin
      bad++;
      $display("FAIL rmid_data: addr=%h wdata=%h fdata=%h drdata=%h required all 0",
               bus.SramAddr, bus.SramWData, bus.FetchData, bus.DataRData);
    end
    bus.FetchReq = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (bus.FetchDone !== 1'b0 || bus.Busy !== 1'b0) begin
        bad++;
        $display("FAIL rmid_hold%0d: fdone=%b busy=%b required 0 0", c, bus.FetchDone, bus.Busy);
      end
    end
    Reset = 1'b1;
    bus.FetchReq  = 1'b1;
    bus.FetchAddr = 11'h0BB;
    tick();
    total++;
    if (bus.FetchGnt !== 1'b1 || bus.SramAddr !== 11'h0BB) begin
      bad++;
      $display("FAIL rmid_regrant: fgnt=%b addr=%h required 1 0bb", bus.FetchGnt, bus.SramAddr);
    end
    tick();
    bus.SramRData = 16'h0F0F;
    tick();
    bus.FetchReq = 1'b0;
    total++;
    if (bus.FetchDone !== 1'b1 || bus.FetchData !== 16'h0F0F) begin
      bad++;
      $display("FAIL rmid_done: fdone=%b fdata=%h required 1 0f0f", bus.FetchDone, bus.FetchData);
    end
    tick();
    total++;
    if (bus.Busy !== 1'b0) begin
      bad++;
      $display("FAIL rmid_idle: busy=%b required 0", bus.Busy);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.FetchReq  = 1'b0;
    bus.FetchAddr = '0;
    bus.DataReq   = 1'b0;
    bus.DataRNW   = 1'b1;
    bus.DataAddr  = '0;
    bus.DataWData = '0;
    bus.SramRData = '0;

    test_reset();
    test_fetch_read();
    test_data_write();
    test_simultaneous();
    test_starvation();
    test_req_drop();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
